// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer arbiter bus: timing-generator inputs, writer valid/ready port,
// single-port RAM strobes and the unpacked pixel stream.
interface vga_fb_arbiter_if #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned PIX_W  = 8
);
   logic                  disp_ena;
   logic [8:0]            col;
   logic [7:0]            row;
   logic                  vblank;
   logic                  wr_only_vblank;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [ADDR_W-1:0]     wr_addr;
   logic [2*PIX_W-1:0]    wr_data;
   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [2*PIX_W-1:0]    mem_wdata;
   logic [2*PIX_W-1:0]    mem_rdata;
   logic                  pix_valid;
   logic [PIX_W-1:0]      pixel_out;
   logic [15:0]           wr_stall_cnt;
   logic [15:0]           frame_cnt;

   modport slave (
      input  disp_ena, col, row, vblank, wr_only_vblank,
      input  wr_valid, wr_addr, wr_data, mem_rdata,
      output wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
      output pix_valid, pixel_out, wr_stall_cnt, frame_cnt
   );

   modport master (
      output disp_ena, col, row, vblank, wr_only_vblank,
      output wr_valid, wr_addr, wr_data, mem_rdata,
      input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
      input  pix_valid, pixel_out, wr_stall_cnt, frame_cnt
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port frame buffer between display fetch (even-column slots,
// absolute priority) and a pixel writer; unpacks 2 pixels per word for display.
module vga_fb_arbiter #(
   parameter int unsigned H_PIXELS = 250,
   parameter int unsigned V_PIXELS = 125,
   parameter int unsigned ADDR_W   = 14,
   parameter int unsigned PIX_W    = 8
) (
   input logic              clk,
   input logic              rst,
   vga_fb_arbiter_if.slave  bus
);

   localparam int unsigned WORD_W = 2 * PIX_W;
   localparam int unsigned HALF_W = H_PIXELS / 2;
   localparam int unsigned CNT_W  = 16;

   if (((H_PIXELS % 2) != 0) || ((V_PIXELS * HALF_W) > (2 ** ADDR_W))) begin : g_bad_cfg
      $error("vga_fb_arbiter: H_PIXELS must be even and the frame must fit in ADDR_W");
   end

   logic              is_rd;
   logic              is_wr;
   logic [ADDR_W-1:0] disp_addr;

   logic              pix_valid_q, pix_valid_d;
   logic              rd_q, rd_d;
   logic              odd_q, odd_d;
   logic              vblank_q, vblank_d;
   logic [PIX_W-1:0]  hold_q, hold_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

   assign disp_addr = ADDR_W'(bus.row) * ADDR_W'(HALF_W) + ADDR_W'(bus.col[8:1]);

   // Slot decision: display read, then writer, then idle; all strobes dead in reset.
   always_comb begin
      is_rd         = 1'b0;
      is_wr         = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (!rst) begin
         is_rd = bus.disp_ena && !bus.col[0];
         is_wr = !is_rd && bus.wr_valid && (!bus.wr_only_vblank || bus.vblank);
      end
      if (is_rd) begin
         bus.mem_addr = disp_addr;
      end else if (is_wr) begin
         bus.mem_addr  = bus.wr_addr;
         bus.mem_wdata = bus.wr_data;
      end
      bus.mem_en   = is_rd || is_wr;
      bus.mem_we   = is_wr;
      bus.wr_ready = is_wr;
   end

   // A line only goes valid once its first read result is in flight, so a
   // mid-line reset release stays blank until the next even column.
   always_comb begin
      rd_d        = is_rd;
      odd_d       = bus.disp_ena && bus.col[0];
      pix_valid_d = bus.disp_ena && (is_rd || pix_valid_q);
      vblank_d    = bus.vblank;
      hold_d      = hold_q;
      if (rd_q) begin
         hold_d = bus.mem_rdata[WORD_W-1:PIX_W];
      end
      stall_cnt_d = stall_cnt_q;
      if (bus.wr_valid && !bus.wr_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      frame_cnt_d = frame_cnt_q;
      if (bus.vblank && !vblank_q) begin
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_valid_q <= 1'b0;
         rd_q        <= 1'b0;
         odd_q       <= 1'b0;
         vblank_q    <= 1'b0;
         hold_q      <= '0;
         stall_cnt_q <= '0;
         frame_cnt_q <= '0;
      end else begin
         pix_valid_q <= pix_valid_d;
         rd_q        <= rd_d;
         odd_q       <= odd_d;
         vblank_q    <= vblank_d;
         hold_q      <= hold_d;
         stall_cnt_q <= stall_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Low pixel comes straight off the RAM data the cycle after the read.
   always_comb begin
      bus.pixel_out = '0;
      if (pix_valid_q) begin
         if (rd_q) begin
            bus.pixel_out = bus.mem_rdata[PIX_W-1:0];
         end else if (odd_q) begin
            bus.pixel_out = hold_q;
         end
      end
   end

   assign bus.pix_valid    = pix_valid_q;
   assign bus.wr_stall_cnt = stall_cnt_q;
   assign bus.frame_cnt    = frame_cnt_q;

endmodule
